// File: rtl/nubus_pkg.sv
// Shared NuBus target types: FSM states, ACK status codes, byte-lane decode constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package nubus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_MEM   = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Encoded directly as the inverted {tm1n_o, tm0n_o} driven during ACK.
    typedef enum logic [1:0] {
        STAT_COMPLETE = 2'b00,
        STAT_ERROR    = 2'b01,
        STAT_TIMEOUT  = 2'b10
    } status_t;

    localparam logic [1:0] AD_WORD    = 2'b00;
    localparam logic [1:0] AD_HALF_LO = 2'b01;
    localparam logic [1:0] AD_BLOCK   = 2'b10;
    localparam logic [1:0] AD_HALF_HI = 2'b11;

    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;

    function automatic logic [3:0] byte_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/nubus_lane_decode.sv
// Maps NuBus transfer size (tm0, ad[1:0]) to a byte-lane mask and flags block transfers.
// Combinational, zero latency; no flow control.
module nubus_lane_decode
    import nubus_pkg::*;
(
    input  logic       tm0,
    input  logic [1:0] ad_lo,
    output logic [3:0] mask,
    output logic       block
);

    always_comb begin
        mask  = MASK_NONE;
        block = 1'b0;
        if (tm0) begin
            mask = byte_mask(ad_lo);
        end else begin
            case (ad_lo)
                AD_WORD:    mask = MASK_WORD;
                AD_HALF_LO: mask = MASK_HALF_LO;
                AD_HALF_HI: mask = MASK_HALF_HI;
                default:    block = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/nubus_target.sv
// NuBus slave bridging slot/super-slot accesses onto a simple valid/ready memory port.
// Read: mem_valid one clock after START, write: two; ACK the clock after mem_ready or wait timeout.
module nubus_target
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOTS_ADDRESS = 4'hF,
    parameter bit         SUPERSLOTS_EN = 1'b1,
    parameter int         WAIT_W        = 8
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic [3:0]  nub_idn,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm1n,
    input  logic        nub_tm0n,
    input  logic [31:0] nub_adn_i,
    output logic [31:0] nub_adn_o,
    output logic        nub_adoe,
    output logic        nub_ackn_o,
    output logic        nub_tm1n_o,
    output logic        nub_tm0n_o,
    output logic        nub_ctloe,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    state_t              state, state_n;
    status_t             status_q;
    logic                is_read_q;
    logic [31:0]         rdata_q;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;

    logic [31:0] ad;
    logic        tm1, tm0;
    logic [3:0]  slot_id;
    logic        start, hit, accept, timeout;
    logic [3:0]  lane_mask;
    logic        lane_block;

    assign ad      = ~nub_adn_i;
    assign tm1     = ~nub_tm1n;
    assign tm0     = ~nub_tm0n;
    assign slot_id = ~nub_idn;

    // START with ACK also low is an attention cycle, not a transaction.
    assign start  = ~nub_startn & nub_ackn;
    assign hit    = (ad[31:24] == {SLOTS_ADDRESS, slot_id})
                  | (SUPERSLOTS_EN && (ad[31:28] == slot_id));
    assign accept = (state == S_IDLE) & start & hit;

    assign wait_next = wait_cnt + 1'b1;
    assign timeout   = (state == S_MEM) & ~mem_ready & (wait_next == {WAIT_W{1'b1}});

    nubus_lane_decode u_lane_decode (
        .tm0   (tm0),
        .ad_lo (ad[1:0]),
        .mask  (lane_mask),
        .block (lane_block)
    );

    always_ff @(negedge nub_clkn) begin
        if (!nub_resetn) state <= S_IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n    = state;
        mem_valid  = 1'b0;
        nub_ctloe  = 1'b0;
        nub_ackn_o = 1'b1;
        nub_tm1n_o = 1'b1;
        nub_tm0n_o = 1'b1;
        nub_adoe   = 1'b0;
        nub_adn_o  = 32'hFFFF_FFFF;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (lane_block) state_n = S_ACK;
                    else if (tm1)   state_n = S_WDATA;
                    else            state_n = S_MEM;
                end
            end
            S_WDATA: state_n = S_MEM;
            S_MEM: begin
                mem_valid = 1'b1;
                if (mem_ready || timeout) state_n = S_ACK;
            end
            S_ACK: begin
                state_n                  = S_IDLE;
                nub_ctloe                = 1'b1;
                nub_ackn_o               = 1'b0;
                {nub_tm1n_o, nub_tm0n_o} = status_q;
                if (is_read_q && (status_q == STAT_COMPLETE)) begin
                    nub_adoe  = 1'b1;
                    nub_adn_o = ~rdata_q;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(negedge nub_clkn) begin
        if (!nub_resetn) begin
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_write <= MASK_NONE;
            is_read_q <= 1'b0;
            status_q  <= STAT_COMPLETE;
            rdata_q   <= 32'h0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                mem_addr  <= {ad[31:2], 2'b00};
                mem_write <= (tm1 && !lane_block) ? lane_mask : MASK_NONE;
                is_read_q <= ~tm1;
                status_q  <= lane_block ? STAT_ERROR : STAT_COMPLETE;
            end
            if (state == S_WDATA) mem_wdata <= ad;
            // Held at zero outside MEM so every MEM entry starts a fresh count.
            if (state == S_MEM) wait_cnt <= wait_next;
            else                wait_cnt <= '0;
            if ((state == S_MEM) && mem_ready) rdata_q <= mem_rdata;
            if (timeout) status_q <= STAT_TIMEOUT;
        end
    end

endmodule

// File: tb/tb_nubus_target.sv
// Directed bench for nubus_target: vector table for single-cycle behaviour plus
// hand-written sequences for wait states, timeout, back-to-back starts and mid-transfer reset.
module tb_nubus_target;

    logic        nub_clkn = 1'b1;
    logic        nub_resetn;
    logic [3:0]  nub_idn;
    logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
    logic [31:0] nub_adn_i, nub_adn_o;
    logic        nub_adoe, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_ctloe;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_write;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // {ctloe, ackn_o, tm1n_o, tm0n_o, adoe}
    localparam logic [4:0] CTL_IDLE = 5'b01110;
    localparam logic [4:0] CTL_OK   = 5'b10000;
    localparam logic [4:0] CTL_RD   = 5'b10001;
    localparam logic [4:0] CTL_ERR  = 5'b10010;
    localparam logic [4:0] CTL_TO   = 5'b10100;

    nubus_target #(
        .SLOTS_ADDRESS (4'hF),
        .SUPERSLOTS_EN (1'b1),
        .WAIT_W        (4)
    ) dut (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .nub_idn    (nub_idn),
        .nub_startn (nub_startn),
        .nub_ackn   (nub_ackn),
        .nub_tm1n   (nub_tm1n),
        .nub_tm0n   (nub_tm0n),
        .nub_adn_i  (nub_adn_i),
        .nub_adn_o  (nub_adn_o),
        .nub_adoe   (nub_adoe),
        .nub_ackn_o (nub_ackn_o),
        .nub_tm1n_o (nub_tm1n_o),
        .nub_tm0n_o (nub_tm0n_o),
        .nub_ctloe  (nub_ctloe),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 nub_clkn = ~nub_clkn;

    typedef struct {
        logic        rstn, startn, ackn, tm1n, tm0n;
        logic [31:0] adn;
        logic        rdy;
        logic        mv;
        logic [3:0]  mw;
        logic [4:0]  ctl;
        logic        chk;
        logic [31:0] addr, wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rstn, startn, ackn, tm1n, tm0n,
                       input logic [31:0] ad, input logic rdy,
                       input logic mv, input logic [3:0] mw, input logic [4:0] ctl,
                       input logic chk, input logic [31:0] addr, wdata);
        vec_t v;
        v.rstn = rstn; v.startn = startn; v.ackn = ackn; v.tm1n = tm1n; v.tm0n = tm0n;
        v.adn = ~ad; v.rdy = rdy; v.mv = mv; v.mw = mw; v.ctl = ctl;
        v.chk = chk; v.addr = addr; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rstn, startn, ackn, tm1n, tm0n,
                         input logic [31:0] ad, input logic rdy, input logic [31:0] rdata);
        nub_resetn = rstn;
        nub_startn = startn;
        nub_ackn   = ackn;
        nub_tm1n   = tm1n;
        nub_tm0n   = tm0n;
        nub_adn_i  = ~ad;
        mem_ready  = rdy;
        mem_rdata  = rdata;
    endtask

    task automatic idle(input logic rdy, input logic [31:0] rdata);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, rdy, rdata);
    endtask

    // DUT flops on the falling edge; inputs change and outputs are sampled on the rising edge.
    task automatic step();
        @(negedge nub_clkn);
        @(posedge nub_clkn);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {nub_ctloe, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_adoe};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit done;

        nub_idn = ~4'h9;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);

        // rstn startn ackn tm1n tm0n ad rdy | mv mw ctl chk addr wdata
        add(0,1,1,1,1, 32'h0,          0, 0,4'b0000,CTL_IDLE,1, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0,          0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,0,1,0,1, 32'hF900_0010,  0, 0,4'b1111,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'hDEAD_BEEF,  0, 1,4'b1111,CTL_IDLE,1, 32'hF900_0010,  32'hDEAD_BEEF);
        add(1,1,1,1,1, 32'h0,          1, 0,4'b1111,CTL_OK,  0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0,          0, 0,4'b1111,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,0,1,1,1, 32'hF900_0002,  0, 0,4'b0000,CTL_ERR, 0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0,          0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,0,0,0,1, 32'hF900_0000,  0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h5555_AAAA,  0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,0,1,0,1, 32'hF800_0000,  0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h1234_5678,  0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0,          0, 0,4'b0000,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,0,1,0,1, 32'h9000_0001,  0, 0,4'b0011,CTL_IDLE,0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0BAD_F00D,  0, 1,4'b0011,CTL_IDLE,1, 32'h9000_0000,  32'h0BAD_F00D);
        add(1,1,1,1,1, 32'h0,          1, 0,4'b0011,CTL_OK,  0, 32'h0,          32'h0);
        add(1,1,1,1,1, 32'h0,          0, 0,4'b0011,CTL_IDLE,0, 32'h0,          32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].startn, vecs[i].ackn, vecs[i].tm1n, vecs[i].tm0n,
                  ~vecs[i].adn, vecs[i].rdy, 32'h0);
            step();
            chk($sformatf("v%0d_mem_valid", i), {31'h0, mem_valid}, {31'h0, vecs[i].mv});
            chk($sformatf("v%0d_ctl", i), {27'h0, ctl_now()}, {27'h0, vecs[i].ctl});
            if (vecs[i].mv || !vecs[i].rstn)
                chk($sformatf("v%0d_mem_write", i), {28'h0, mem_write}, {28'h0, vecs[i].mw});
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
            end
        end

        // Byte read with three wait states.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF900_0003, 1'b0, 32'h0);
        step();
        chk("rd_valid_rise", {31'h0, mem_valid}, 32'h1);
        chk("rd_mem_write", {28'h0, mem_write}, 32'h0);
        chk("rd_mem_addr", mem_addr, 32'hF900_0000);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            idle(k == 3, (k == 3) ? 32'h1122_3344 : 32'hBAD0_BAD0 + k);
            step();
            n++;
            if (nub_ctloe) done = 1'b1;
        end
        chk("rd_ack_latency", n, 32'd4);
        chk("rd_ack_ctl", {27'h0, ctl_now()}, {27'h0, CTL_RD});
        chk("rd_adn_o", nub_adn_o, ~32'h1122_3344);
        idle(1'b0, 32'h0);
        step();
        chk("rd_release", {27'h0, ctl_now()}, {27'h0, CTL_IDLE});

        // Timeout with mem_ready held low, then starts during ACK and in the following IDLE.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF900_0020, 1'b0, 32'h0);
        step();
        n = 0;
        while (mem_valid === 1'b1 && n < 40) begin
            n++;
            idle(1'b0, 32'h0);
            step();
        end
        chk("to_mem_clocks", n, 32'd15);
        chk("to_ack_ctl", {27'h0, ctl_now()}, {27'h0, CTL_TO});
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF900_0004, 1'b0, 32'h0);
        step();
        chk("b2b_ignored_in_ack", {31'h0, mem_valid}, 32'h0);
        chk("b2b_idle_ctl", {27'h0, ctl_now()}, {27'h0, CTL_IDLE});
        step();
        chk("b2b_accepted", {31'h0, mem_valid}, 32'h1);
        chk("b2b_mem_addr", mem_addr, 32'hF900_0004);
        idle(1'b1, 32'hCAFE_F00D);
        step();
        chk("b2b_ack_ctl", {27'h0, ctl_now()}, {27'h0, CTL_RD});
        chk("b2b_adn_o", nub_adn_o, ~32'hCAFE_F00D);
        idle(1'b0, 32'h0);
        step();

        // Reset while in MEM, then a halfword write completes normally.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF900_0008, 1'b0, 32'h0);
        step();
        chk("rst_pre_valid", {31'h0, mem_valid}, 32'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h7777_7777);
        step();
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_ctl", {27'h0, ctl_now()}, {27'h0, CTL_IDLE});
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_write", {28'h0, mem_write}, 32'h0);
        idle(1'b0, 32'h0);
        step();
        chk("rst_no_ack", {27'h0, ctl_now()}, {27'h0, CTL_IDLE});
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hF900_000F, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
        step();
        chk("post_rst_valid", {31'h0, mem_valid}, 32'h1);
        chk("post_rst_mem_write", {28'h0, mem_write}, 32'hC);
        chk("post_rst_mem_addr", mem_addr, 32'hF900_000C);
        chk("post_rst_mem_wdata", mem_wdata, 32'h1234_5678);
        idle(1'b1, 32'h0);
        step();
        chk("post_rst_ack_ctl", {27'h0, ctl_now()}, {27'h0, CTL_OK});
        idle(1'b0, 32'h0);
        step();
        chk("post_rst_idle", {27'h0, ctl_now()}, {27'h0, CTL_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
